updi_transaction_engine: RTL and testbench
==========================================

Name: updi_transaction_engine

Overview:
Parametrised successor to the UPDI command/response bridge. Executes one complete UPDI transaction per start pulse: SYNC, opcode, a data payload with per-byte ACK waits, then an optional response read. Adds behaviour the previous bridge lacks: half-duplex echo consumption, an ACK/response timeout, and a done/error status report. Sits between the instruction/programming controller and the UART TX/RX FIFOs.

Parameters:
MAX_DATA_SIZE, 16, max payload bytes and max response bytes per transaction
LEN_BITS, $clog2(MAX_DATA_SIZE+1), width of length fields (must hold MAX_DATA_SIZE)
TIMEOUT_CYCLES, 65535, idle clk cycles allowed while waiting for any RX byte
TIMEOUT_BITS, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
opcode  in  8  UPDI instruction byte; sampled at start
tx_data  in  8 x MAX_DATA_SIZE  payload bytes; sampled at start
tx_len  in  LEN_BITS  payload byte count; sampled at start
ack_mask  in  MAX_DATA_SIZE  bit i=1: wait for ACK after payload byte i
rx_len  in  LEN_BITS  response bytes to read; sampled at start
start  in  1  begin transaction; honoured only when ready=1
ready  out  1  engine idle
done  out  1  one-cycle completion pulse
error  out  1  transaction failed; valid at done, held until next accepted start
error_code  out  2  0 none, 1 echo mismatch, 2 bad ACK, 3 timeout
out_rx_fifo_data  out  8  response byte
out_rx_fifo_wr_en  out  1  push response byte
out_rx_fifo_full  in  1  response FIFO full
uart_rx_fifo_data  in  8  RX byte (first-word-fall-through: valid while !empty)
uart_rx_fifo_rd_en  out  1  pop RX byte
uart_rx_fifo_empty  in  1  RX FIFO empty
uart_tx_fifo_data  out  8  TX byte
uart_tx_fifo_wr_en  out  1  push TX byte
uart_tx_fifo_full  in  1  TX FIFO full

Behaviour:
- Reset: state IDLE; ready=1; done, error, all wr_en/rd_en = 0; error_code=0; out data = 0; counters cleared. Reset mid-transaction aborts immediately with no done pulse; bytes already pushed are not retracted.
- IDLE: start & ready latches opcode, tx_data, ack_mask, rx_len, and tx_len clamped to MAX_DATA_SIZE. Clears error/error_code; ready drops next cycle. start while busy is ignored.
- States: IDLE -> SEND(0x55) -> ECHO -> SEND(opcode) -> ECHO -> {SEND(tx_data[i]) -> ECHO -> [ACK if ack_mask[i]]} for i=0..tx_len-1 -> RX (if rx_len>0) -> FIN -> IDLE.
- SEND: uart_tx_fifo_wr_en=1 for exactly one cycle, only when !uart_tx_fifo_full; stalls otherwise. Exactly one byte per SEND.
- ECHO: each sent byte returns on the half-duplex line. When !empty: rd_en=1 for one cycle; byte consumed.
- ACK: when !empty, pop one byte. 0x40 continues; any other value -> error_code=2, go to FIN.
- RX: pop a byte and push it to the response FIFO in the same cycle, only when !uart_rx_fifo_empty & !out_rx_fifo_full. Finish after rx_len transfers. out_rx_fifo_full never counts toward timeout.
- Timeout: counter runs in ECHO/ACK/RX while uart_rx_fifo_empty. It clears on every RX pop and on state entry. Reaching TIMEOUT_CYCLES -> error_code=3, go to FIN.
- FIN: done=1 for one cycle; error=(error_code!=0); next state IDLE with ready=1. Earliest start accepted the cycle after done.
- First error aborts the transaction: no further TX/RX FIFO traffic.
- tx_len=0 sends SYNC+opcode only. rx_len=0 skips RX. tx_len>MAX_DATA_SIZE is clamped.

Optional Feature:
UPDI_ECHO_CHECK_EN: when defined, each ECHO byte is compared to the byte sent; a mismatch sets error_code=1 and goes to FIN. When undefined, echo bytes are still popped but not compared, and error_code 1 is never produced.

Test Plan:
- opcode=0x04, tx_len=0, rx_len=1, loopback echo then RX byte 0x1E -> TX 0x55,0x04; response FIFO gets 0x1E; done with error=0, code 0.
- opcode=0x44, tx_len=2 {0x12,0x34}, ack_mask=2'b10, ACK 0x40 after byte 1 -> TX 0x55,0x44,0x12,0x34; done, error=0; ACK wait only after 0x34.
- Same as previous but ACK byte 0x00 -> done with error=1, code 2; no further TX writes.
- TIMEOUT_CYCLES=20, rx_len=1, no RX byte after echoes -> done exactly 20 empty cycles after the last pop; code 3.
- uart_tx_fifo_full held 5 cycles mid-payload; out_rx_fifo_full held 3 cycles in RX -> no lost or duplicated bytes, no timeout; start while busy ignored; rst mid-RX -> ready=1, no done.
- With UPDI_ECHO_CHECK_EN, echo of 0x12 returned as 0x13 -> code 1. Without the macro, same stimulus -> completes, code 0.

Source files
------------

// File: rtl/updi_transaction_engine.sv
// UPDI transaction engine.
// Runs one complete UPDI transaction per accepted start pulse: SYNC (0x55), opcode, then
// tx_len payload bytes. Every transmitted byte comes back on the half-duplex line and is
// popped as an echo. Payload byte i is optionally followed by an ACK (0x40) wait, and an
// optional rx_len-byte response is moved from the UART RX FIFO to the response FIFO.
// Waits on the RX line time out after TIMEOUT_CYCLES empty cycles. The first error aborts
// the transaction, and the result is reported with a one-cycle done pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   opcode, tx_data,     transaction description, sampled on an accepted start
//   tx_len, ack_mask,
//   rx_len
//   start / ready        request / engine idle
//   done                 one-cycle completion pulse
//   error, error_code    0 none, 1 echo mismatch, 2 bad ACK, 3 timeout; held until next start
//   out_rx_fifo_*        response FIFO push side
//   uart_rx_fifo_*       UART RX FIFO pop side (first-word-fall-through)
//   uart_tx_fifo_*       UART TX FIFO push side
//
// Build option: define UPDI_ECHO_CHECK_EN to compare every echo against the byte sent.
// Without it, echoes are popped and discarded.
module updi_transaction_engine #(
  parameter int unsigned MAX_DATA_SIZE  = 16,
  parameter int unsigned LEN_BITS       = $clog2(MAX_DATA_SIZE + 1),
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    opcode,
  input  logic [MAX_DATA_SIZE-1:0][7:0] tx_data,
  input  logic [LEN_BITS-1:0]           tx_len,
  input  logic [MAX_DATA_SIZE-1:0]      ack_mask,
  input  logic [LEN_BITS-1:0]           rx_len,
  input  logic                          start,
  output logic                          ready,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    error_code,
  output logic [7:0]                    out_rx_fifo_data,
  output logic                          out_rx_fifo_wr_en,
  input  logic                          out_rx_fifo_full,
  input  logic [7:0]                    uart_rx_fifo_data,
  output logic                          uart_rx_fifo_rd_en,
  input  logic                          uart_rx_fifo_empty,
  output logic [7:0]                    uart_tx_fifo_data,
  output logic                          uart_tx_fifo_wr_en,
  input  logic                          uart_tx_fifo_full
);

  localparam logic [7:0]              SyncByte = 8'h55;
  localparam logic [7:0]              AckByte  = 8'h40;
  localparam logic [LEN_BITS-1:0]     MaxLen   = LEN_BITS'(MAX_DATA_SIZE);
  localparam logic [LEN_BITS-1:0]     LenOne   = LEN_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] ToLast   = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ErrNone = 2'd0, ErrEcho = 2'd1, ErrAck = 2'd2, ErrTimeout = 2'd3;

  typedef enum logic [2:0] {StIdle, StSend, StEcho, StAck, StRx, StFin} state_e;
  // Which byte of the outgoing stream is current.
  typedef enum logic [1:0] {PhSync, PhOp, PhData} phase_e;

  state_e                          state_q, adv_state, post_state;
  phase_e                          phase_q, adv_phase;
  logic [7:0]                      opcode_q;
  logic [MAX_DATA_SIZE-1:0][7:0]   tx_data_q;  // shifted down so the current byte is [0]
  logic [MAX_DATA_SIZE-1:0]        ack_mask_q; // shifted in step with tx_data_q
  logic [LEN_BITS-1:0]             tx_rem_q;   // payload bytes left, including the current one
  logic [LEN_BITS-1:0]             rx_rem_q;
  logic [TIMEOUT_BITS-1:0]         to_cnt_q;
  logic [1:0]                      error_code_q;

  logic [7:0] tx_byte;
  logic       rx_avail;
  logic       to_hit;
  logic       echo_bad;

  always_comb begin
    unique case (phase_q)
      PhSync:  tx_byte = SyncByte;
      PhOp:    tx_byte = opcode_q;
      default: tx_byte = tx_data_q[0];
    endcase
  end

  assign rx_avail = !uart_rx_fifo_empty;
  // Only used while the RX FIFO is empty: this cycle is the TIMEOUT_CYCLES-th empty one.
  assign to_hit   = (to_cnt_q == ToLast);

`ifdef UPDI_ECHO_CHECK_EN
  assign echo_bad = (uart_rx_fifo_data != tx_byte);
`else
  assign echo_bad = 1'b0;
`endif

  // Where to go once the current byte (and its ACK, if any) is finished.
  always_comb begin
    post_state = (rx_rem_q != '0) ? StRx : StFin;
    adv_state  = post_state;
    adv_phase  = phase_q;
    unique case (phase_q)
      PhSync: begin
        adv_state = StSend;
        adv_phase = PhOp;
      end
      PhOp: begin
        if (tx_rem_q != '0) begin
          adv_state = StSend;
          adv_phase = PhData;
        end
      end
      default: begin
        if (tx_rem_q > LenOne) adv_state = StSend;
      end
    endcase
  end

  assign ready              = (state_q == StIdle);
  assign done               = (state_q == StFin);
  assign error              = (error_code_q != ErrNone);
  assign error_code         = error_code_q;
  assign uart_tx_fifo_wr_en = (state_q == StSend) && !uart_tx_fifo_full;
  assign uart_tx_fifo_data  = (state_q == StSend) ? tx_byte : 8'h00;
  assign out_rx_fifo_wr_en  = (state_q == StRx) && rx_avail && !out_rx_fifo_full;
  assign out_rx_fifo_data   = out_rx_fifo_wr_en ? uart_rx_fifo_data : 8'h00;
  assign uart_rx_fifo_rd_en = ((state_q == StEcho || state_q == StAck) && rx_avail) ||
                              out_rx_fifo_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= PhSync;
      opcode_q     <= 8'h00;
      tx_data_q    <= '0;
      ack_mask_q   <= '0;
      tx_rem_q     <= '0;
      rx_rem_q     <= '0;
      to_cnt_q     <= '0;
      error_code_q <= ErrNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          to_cnt_q <= '0;
          if (start) begin
            opcode_q     <= opcode;
            tx_data_q    <= tx_data;
            ack_mask_q   <= ack_mask;
            tx_rem_q     <= (tx_len > MaxLen) ? MaxLen : tx_len;
            rx_rem_q     <= rx_len;
            phase_q      <= PhSync;
            error_code_q <= ErrNone;
            state_q      <= StSend;
          end
        end
        StSend: begin
          to_cnt_q <= '0;
          if (!uart_tx_fifo_full) state_q <= StEcho;
        end
        StEcho, StAck: begin
          if (rx_avail) begin
            to_cnt_q <= '0;
            if (state_q == StEcho && echo_bad) begin
              error_code_q <= ErrEcho;
              state_q      <= StFin;
            end else if (state_q == StAck && uart_rx_fifo_data != AckByte) begin
              error_code_q <= ErrAck;
              state_q      <= StFin;
            end else if (state_q == StEcho && phase_q == PhData && ack_mask_q[0]) begin
              state_q <= StAck;
            end else begin
              state_q <= adv_state;
              phase_q <= adv_phase;
              if (phase_q == PhData) begin
                tx_data_q  <= tx_data_q >> 8;
                ack_mask_q <= ack_mask_q >> 1;
                tx_rem_q   <= tx_rem_q - LenOne;
              end
            end
          end else if (to_hit) begin
            error_code_q <= ErrTimeout;
            state_q      <= StFin;
          end else begin
            to_cnt_q <= to_cnt_q + TIMEOUT_BITS'(1);
          end
        end
        StRx: begin
          if (rx_avail) begin
            // A full response FIFO stalls the transfer without advancing the timeout.
            if (!out_rx_fifo_full) begin
              to_cnt_q <= '0;
              rx_rem_q <= rx_rem_q - LenOne;
              if (rx_rem_q == LenOne) state_q <= StFin;
            end
          end else if (to_hit) begin
            error_code_q <= ErrTimeout;
            state_q      <= StFin;
          end else begin
            to_cnt_q <= to_cnt_q + TIMEOUT_BITS'(1);
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_transaction_engine.sv
module tb_updi_transaction_engine;

  localparam int unsigned MAX = 4;
  localparam int unsigned LB  = 3;
  localparam int unsigned TO  = 20;
`ifdef UPDI_ECHO_CHECK_EN
  localparam bit EchoChk = 1'b1;
`else
  localparam bit EchoChk = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          opcode;
  logic [MAX-1:0][7:0] tx_data;
  logic [LB-1:0]       tx_len;
  logic [MAX-1:0]      ack_mask;
  logic [LB-1:0]       rx_len;
  logic                start;
  logic                ready, done, error;
  logic [1:0]          error_code;
  logic [7:0]          out_rx_fifo_data;
  logic                out_rx_fifo_wr_en;
  logic                out_rx_fifo_full = 1'b0;
  logic [7:0]          uart_rx_fifo_data = 8'h00;
  logic                uart_rx_fifo_rd_en;
  logic                uart_rx_fifo_empty = 1'b1;
  logic [7:0]          uart_tx_fifo_data;
  logic                uart_tx_fifo_wr_en;
  logic                uart_tx_fifo_full = 1'b0;

  always #5 clk = ~clk;

  updi_transaction_engine #(
    .MAX_DATA_SIZE (MAX),
    .LEN_BITS      (LB),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_BITS  (5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .opcode            (opcode),
    .tx_data           (tx_data),
    .tx_len            (tx_len),
    .ack_mask          (ack_mask),
    .rx_len            (rx_len),
    .start             (start),
    .ready             (ready),
    .done              (done),
    .error             (error),
    .error_code        (error_code),
    .out_rx_fifo_data  (out_rx_fifo_data),
    .out_rx_fifo_wr_en (out_rx_fifo_wr_en),
    .out_rx_fifo_full  (out_rx_fifo_full),
    .uart_rx_fifo_data (uart_rx_fifo_data),
    .uart_rx_fifo_rd_en(uart_rx_fifo_rd_en),
    .uart_rx_fifo_empty(uart_rx_fifo_empty),
    .uart_tx_fifo_data (uart_tx_fifo_data),
    .uart_tx_fifo_wr_en(uart_tx_fifo_wr_en),
    .uart_tx_fifo_full (uart_tx_fifo_full)
  );

  // Line / target model state.
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  logic [7:0] resplog[$];
  logic [7:0] resp_src[$];
  logic [7:0] ack_vals[MAX];
  int corrupt_k = -1;
  int total_tx = 0;
  int tx_stall_after = -1;
  bit out_stall_arm = 1'b0;
  bit resp_pushed = 1'b0;
  int tx_full_cnt = 0;
  int out_full_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;

  // Reference expectations.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];
  int exp_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Half-duplex line: every TX byte is echoed (optionally corrupted), the target appends an
  // ACK where requested, and the response bytes follow the last transmitted byte.
  always begin : line_model
    bit         s_txwr, s_rd, s_outwr, s_done;
    logic [7:0] s_txd, s_outd;
    int         k;
    @(negedge clk);
    cyc++;
    s_txwr  = uart_tx_fifo_wr_en;
    s_txd   = uart_tx_fifo_data;
    s_rd    = uart_rx_fifo_rd_en;
    s_outwr = out_rx_fifo_wr_en;
    s_outd  = out_rx_fifo_data;
    s_done  = done;
    if (s_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_rd) last_pop_cyc = cyc;
    @(posedge clk);
    #1;
    if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
    if (s_outwr) resplog.push_back(s_outd);
    if (s_txwr) begin
      k = txlog.size();
      txlog.push_back(s_txd);
      rxq.push_back((k == corrupt_k) ? (s_txd ^ 8'h01) : s_txd);
      if (k >= 2 && ack_mask[k-2]) rxq.push_back(ack_vals[k-2]);
      if (k == total_tx - 1) begin
        foreach (resp_src[i]) rxq.push_back(resp_src[i]);
        resp_pushed = 1'b1;
      end
      if (k == tx_stall_after) tx_full_cnt = 5;
    end
    if (out_stall_arm && resp_pushed && resp_src.size() > 0 && rxq.size() == resp_src.size())
    begin
      out_full_cnt  = 3;
      out_stall_arm = 1'b0;
    end
    uart_tx_fifo_full = (tx_full_cnt > 0);
    if (tx_full_cnt > 0) tx_full_cnt--;
    out_rx_fifo_full = (out_full_cnt > 0);
    if (out_full_cnt > 0) out_full_cnt--;
    uart_rx_fifo_empty = (rxq.size() == 0);
    uart_rx_fifo_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected transaction outcome computed from the protocol rules.
  task automatic model();
    int n;
    logic [7:0] b;
    exp_tx.delete();
    exp_resp.delete();
    exp_code = 0;
    n = (int'(tx_len) > int'(MAX)) ? int'(MAX) : int'(tx_len);
    total_tx = n + 2;
    for (int k = 0; k < n + 2; k++) begin
      b = (k == 0) ? 8'h55 : (k == 1) ? opcode : tx_data[k-2];
      exp_tx.push_back(b);
      if (EchoChk && k == corrupt_k) begin
        exp_code = 1;
        break;
      end
      if (k >= 2 && ack_mask[k-2] && ack_vals[k-2] != 8'h40) begin
        exp_code = 2;
        break;
      end
    end
    if (exp_code == 0) begin
      for (int i = 0; i < int'(rx_len) && i < resp_src.size(); i++) exp_resp.push_back(resp_src[i]);
      if (resp_src.size() < int'(rx_len)) exp_code = 3;
    end
  endtask

  task automatic clear_cfg();
    corrupt_k      = -1;
    tx_stall_after = -1;
    out_stall_arm  = 1'b0;
    resp_pushed    = 1'b0;
    resp_src.delete();
    for (int i = 0; i < int'(MAX); i++) ack_vals[i] = 8'h40;
    ack_mask = '0;
    tx_data  = '0;
  endtask

  task automatic run_txn(input string tag, input bit busy_start);
    int  d0;
    bit  seen;
    logic [31:0] v;
    model();
    txlog.delete();
    resplog.delete();
    rxq.delete();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "/ready_drop"}, 32'(ready), 32'd0);
    d0 = done_cnt;
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #1;
      start  = 1'b1;
      opcode = ~opcode;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/error"}, 32'(error), 32'(exp_code != 0));
    check({tag, "/code"}, 32'(error_code), 32'(exp_code));
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/ready_back"}, 32'(ready), 32'd1);
    check({tag, "/error_held"}, 32'(error), 32'(exp_code != 0));
    check({tag, "/done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "/tx_count"}, 32'(txlog.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) begin
      v = (i < txlog.size()) ? 32'(txlog[i]) : 32'hDEAD;
      check({tag, "/tx_byte"}, v, 32'(exp_tx[i]));
    end
    check({tag, "/resp_count"}, 32'(resplog.size()), 32'(exp_resp.size()));
    foreach (exp_resp[i]) begin
      v = (i < resplog.size()) ? 32'(resplog[i]) : 32'hDEAD;
      check({tag, "/resp_byte"}, v, 32'(exp_resp[i]));
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    int  d0;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = 8'h00;
    tx_len = '0;
    rx_len = '0;
    clear_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/ready", 32'(ready), 32'd1);
    check("rst/done", 32'(done), 32'd0);
    check("rst/error", 32'(error), 32'd0);
    check("rst/code", 32'(error_code), 32'd0);
    check("rst/tx_wr", 32'(uart_tx_fifo_wr_en), 32'd0);
    check("rst/rx_rd", 32'(uart_rx_fifo_rd_en), 32'd0);
    check("rst/out_wr", 32'(out_rx_fifo_wr_en), 32'd0);
    check("rst/out_data", 32'(out_rx_fifo_data), 32'd0);
    check("rst/tx_data", 32'(uart_tx_fifo_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read with no payload.
    clear_cfg();
    opcode = 8'h04; tx_len = 3'd0; rx_len = 3'd1;
    resp_src.push_back(8'h1E);
    run_txn("lds", 1'b0);

    // Two payload bytes, ACK only after the second.
    clear_cfg();
    opcode = 8'h44; tx_len = 3'd2; rx_len = 3'd0;
    tx_data[0] = 8'h12; tx_data[1] = 8'h34; ack_mask = 4'b0010;
    run_txn("sts_ack", 1'b0);

    // Same, bad ACK.
    clear_cfg();
    opcode = 8'h44; tx_len = 3'd2; rx_len = 3'd0;
    tx_data[0] = 8'h12; tx_data[1] = 8'h34; ack_mask = 4'b0010; ack_vals[1] = 8'h00;
    run_txn("sts_nack", 1'b0);

    // Response never arrives: done follows 20 empty waiting cycles after the last pop.
    clear_cfg();
    opcode = 8'h08; tx_len = 3'd0; rx_len = 3'd1;
    run_txn("timeout", 1'b0);
    check("timeout/latency", 32'(done_cyc - last_pop_cyc), 32'(TO + 1));

    // Back-pressure on both FIFOs plus a start pulse while busy.
    clear_cfg();
    opcode = 8'h24; tx_len = 3'd3; rx_len = 3'd3;
    tx_data[0] = 8'hA1; tx_data[1] = 8'hB2; tx_data[2] = 8'hC3; ack_mask = 4'b0101;
    resp_src.push_back(8'h5A); resp_src.push_back(8'hC0); resp_src.push_back(8'h0F);
    tx_stall_after = 2; out_stall_arm = 1'b1;
    run_txn("stall", 1'b1);

    // Corrupted echo of 0x12.
    clear_cfg();
    opcode = 8'h44; tx_len = 3'd2; rx_len = 3'd0;
    tx_data[0] = 8'h12; tx_data[1] = 8'h34; corrupt_k = 2;
    run_txn("echo", 1'b0);

    // Payload length beyond the maximum is clamped.
    clear_cfg();
    opcode = 8'h64; tx_len = 3'd7; rx_len = 3'd0;
    tx_data = 32'h4433_2211;
    run_txn("clamp", 1'b0);

    // Reset while waiting for a response: no done, back to idle.
    clear_cfg();
    opcode = 8'h04; tx_len = 3'd0; rx_len = 3'd2;
    model();
    txlog.delete(); resplog.delete(); rxq.delete();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 200 && txlog.size() < 2; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midrst/ready", 32'(ready), 32'd1);
    check("midrst/error", 32'(error), 32'd0);
    repeat (30) @(negedge clk);
    check("midrst/no_done", 32'(done_cnt - d0), 32'd0);

    // Randomised transactions.
    for (int t = 0; t < 40; t++) begin
      clear_cfg();
      opcode = 8'($urandom);
      tx_len = LB'($urandom_range(0, 7));
      rx_len = LB'($urandom_range(0, 5));
      for (int i = 0; i < int'(MAX); i++) begin
        tx_data[i]  = 8'($urandom);
        ack_mask[i] = 1'($urandom);
        ack_vals[i] = ($urandom_range(0, 9) == 0) ? (8'h40 ^ 8'($urandom_range(1, 255))) : 8'h40;
      end
      for (int i = 0; i < int'(rx_len); i++) resp_src.push_back(8'($urandom));
      n = (int'(tx_len) > int'(MAX)) ? int'(MAX) : int'(tx_len);
      if ($urandom_range(0, 7) == 0) corrupt_k = $urandom_range(0, n + 1);
      if ($urandom_range(0, 2) == 0) tx_stall_after = $urandom_range(0, n + 1);
      out_stall_arm = 1'($urandom);
      run_txn("rand", 1'($urandom));
    end

    seen = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
